// File: rtl/twos_complement_serial_converter_if.sv
// Handshake and data bundle for the serial two's-complement / sign-magnitude converter.
// The master issues conversions; the slave (the converter) returns results.
interface twos_complement_serial_converter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             mode;
  logic             in_sign;
  logic [WIDTH-1:0] in_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_data;
  logic             sign;
  logic             overflow;

  modport master (
    output start,
    output mode,
    output in_sign,
    output in_data,
    input  busy,
    input  done,
    input  out_data,
    input  sign,
    input  overflow
  );

  modport slave (
    input  start,
    input  mode,
    input  in_sign,
    input  in_data,
    output busy,
    output done,
    output out_data,
    output sign,
    output overflow
  );
endinterface

// File: rtl/twos_complement_serial_converter.sv
// Multi-cycle converter between two's-complement and sign-magnitude, negating CHUNK bits
// per cycle LSB first so the adder stays narrow for wide operands.
module twos_complement_serial_converter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                               clk,
  input logic                               reset,
  twos_complement_serial_converter_if.slave bus
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(N - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             negate_q, negate_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;

  logic             cap_negate;
  logic             cap_sign;
  logic             cap_ovf;
  logic [CHUNK-1:0] chunk_in;
  logic [CHUNK-1:0] chunk_out;
  logic [CHUNK:0]   chunk_sum;

  // Sign, overflow and negate decisions need the whole operand, so they are made at capture.
  always_comb begin
    if (bus.mode) begin
      cap_negate = bus.in_sign;
      cap_sign   = bus.in_sign & (|bus.in_data);
      cap_ovf    = (~bus.in_sign & bus.in_data[WIDTH-1]) |
                   (bus.in_sign & (bus.in_data > MinNeg));
    end else begin
      cap_negate = bus.in_data[WIDTH-1];
      cap_sign   = bus.in_data[WIDTH-1];
      cap_ovf    = (bus.in_data == MinNeg);
    end
  end

  always_comb begin
    chunk_in = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CntW'(i)) begin
        chunk_in = data_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign chunk_sum = {1'b0, ~chunk_in} + {{CHUNK{1'b0}}, carry_q};
  assign chunk_out = negate_q ? chunk_sum[CHUNK-1:0] : chunk_in;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    negate_d = negate_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          data_d   = bus.in_data;
          negate_d = cap_negate;
          sign_d   = cap_sign;
          ovf_d    = cap_ovf;
          cnt_d    = '0;
          carry_d  = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CntW'(i)) begin
            out_d[i*CHUNK +: CHUNK] = chunk_out;
          end
        end
        carry_d = chunk_sum[CHUNK];
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      negate_q <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      negate_q <= negate_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.out_data = out_q;
  assign bus.sign     = sign_q;
  assign bus.overflow = ovf_q;

  done_single_cycle: assert property (@(posedge clk) disable iff (!reset)
    bus.done |=> !bus.done);
  done_implies_busy: assert property (@(posedge clk) disable iff (!reset)
    bus.done |-> bus.busy);

endmodule

// File: tb/tb_twos_complement_serial_converter.sv
// Scoreboard bench: drivers push expected results from an arithmetic model, monitors pop on done.
// Two instances cover the 8/4 and 32/8 geometries.
module tb_twos_complement_serial_converter;

  typedef struct {
    logic [31:0] out;
    logic        sign;
    logic        ovf;
    int unsigned done_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned errors;
  int unsigned checks;
  exp_t        exp8[$];
  exp_t        exp32[$];

  twos_complement_serial_converter_if #(.WIDTH(8))  if8 ();
  twos_complement_serial_converter_if #(.WIDTH(32)) if32 ();

  twos_complement_serial_converter #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if8)
  );

  twos_complement_serial_converter #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  // Reference: plain modular arithmetic on the value, not on chunks.
  function automatic exp_t model(input int unsigned w, input bit m, input bit s,
                                 input logic [31:0] d);
    exp_t        e;
    logic [63:0] modv, mask, half, x;
    modv = 64'd1 << w;
    mask = modv - 64'd1;
    half = 64'd1 << (w - 1);
    x    = {32'b0, d} & mask;
    e.done_cyc = 0;
    if (!m) begin
      e.sign = (x >= half);
      e.ovf  = (x == half);
      e.out  = 32'(e.sign ? ((modv - x) & mask) : x);
    end else begin
      e.sign = s && (x != 0);
      e.ovf  = (!s && x >= half) || (s && x > half);
      e.out  = 32'(s ? ((modv - x) & mask) : x);
    end
    return e;
  endfunction

  function automatic logic [31:0] pick(input int unsigned w);
    logic [63:0] half;
    half = 64'd1 << (w - 1);
    case ($urandom_range(0, 6))
      0:       return 32'(half);
      1:       return 32'd0;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'(half + 64'd1);
      4:       return 32'(half - 64'd1);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive8(input bit m, input bit s, input logic [7:0] d);
    int unsigned t = 0;
    exp_t        e;
    @(negedge clk);
    while (if8.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (if8.busy) begin
      fail("drive8_busy_timeout");
      return;
    end
    if8.start   = 1'b1;
    if8.mode    = m;
    if8.in_sign = s;
    if8.in_data = d;
    e = model(8, m, s, {24'b0, d});
    e.done_cyc = cyc + 1 + 2;
    exp8.push_back(e);
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic drive32(input bit m, input bit s, input logic [31:0] d);
    int unsigned t = 0;
    exp_t        e;
    @(negedge clk);
    while (if32.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (if32.busy) begin
      fail("drive32_busy_timeout");
      return;
    end
    if32.start   = 1'b1;
    if32.mode    = m;
    if32.in_sign = s;
    if32.in_data = d;
    e = model(32, m, s, d);
    e.done_cyc = cyc + 1 + 4;
    exp32.push_back(e);
    @(negedge clk);
    if32.start = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp8.size() != 0 || exp32.size() != 0 || if8.busy || if32.busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail("drain_timeout");
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && if8.done) begin
      if (exp8.size() == 0) begin
        fail("done8_unexpected");
      end else begin
        e = exp8.pop_front();
        chk("out8", {24'b0, if8.out_data}, e.out);
        chk("sign8", {31'b0, if8.sign}, {31'b0, e.sign});
        chk("ovf8", {31'b0, if8.overflow}, {31'b0, e.ovf});
        chk("latency8", cyc, e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && if32.done) begin
      if (exp32.size() == 0) begin
        fail("done32_unexpected");
      end else begin
        e = exp32.pop_front();
        chk("out32", if32.out_data, e.out);
        chk("sign32", {31'b0, if32.sign}, {31'b0, e.sign});
        chk("ovf32", {31'b0, if32.overflow}, {31'b0, e.ovf});
        chk("latency32", cyc, e.done_cyc);
      end
    end
  end

  initial begin
    cyc    = 0;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if8.start  = 1'b0; if8.mode  = 1'b0; if8.in_sign  = 1'b0; if8.in_data  = '0;
    if32.start = 1'b0; if32.mode = 1'b0; if32.in_sign = 1'b0; if32.in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", {31'b0, if8.busy}, 32'd0);
    chk("rst_done8", {31'b0, if8.done}, 32'd0);
    chk("rst_out8", {24'b0, if8.out_data}, 32'd0);
    chk("rst_flags8", {30'b0, if8.sign, if8.overflow}, 32'd0);
    chk("rst_busy32", {31'b0, if32.busy}, 32'd0);
    chk("rst_out32", if32.out_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including hold-after-done.
    drive8(1'b0, 1'b0, 8'hFB);
    drain();
    repeat (3) @(negedge clk);
    chk("hold_out8", {24'b0, if8.out_data}, 32'h05);
    chk("hold_sign8", {31'b0, if8.sign}, 32'd1);
    chk("hold_ovf8", {31'b0, if8.overflow}, 32'd0);
    drive8(1'b0, 1'b0, 8'h80);
    drive8(1'b0, 1'b0, 8'h00);
    drive8(1'b1, 1'b1, 8'h05);
    drive8(1'b1, 1'b1, 8'h80);
    drive8(1'b1, 1'b0, 8'h80);
    drive8(1'b1, 1'b1, 8'h00);
    drive32(1'b0, 1'b0, 32'hFFFF_FFFF);
    drain();

    // A start one cycle after accept must be ignored.
    drive8(1'b0, 1'b0, 8'hF0);
    if8.start   = 1'b1;
    if8.mode    = 1'b1;
    if8.in_sign = 1'b1;
    if8.in_data = 8'h33;
    @(negedge clk);
    if8.start = 1'b0;
    drain();

    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [31:0] d;
          d = pick(8);
          drive8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d[7:0]);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          drive32(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(32));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    drain();

    // Abort mid-RUN: reset between edges while chunk 1 of 4 is in progress.
    drive32(1'b1, 1'b1, 32'h1234_5678);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp32.delete();
    chk("abort_busy32", {31'b0, if32.busy}, 32'd0);
    chk("abort_done32", {31'b0, if32.done}, 32'd0);
    chk("abort_out32", if32.out_data, 32'd0);
    chk("abort_flags32", {30'b0, if32.sign, if32.overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    drive32(1'b0, 1'b0, 32'h8000_0000);
    drive32(1'b1, 1'b1, 32'h0000_0001);
    drain();

    chk("pending8", exp8.size(), 32'd0);
    chk("pending32", exp32.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
